// File: rtl/risc16_control_unit.sv
// RiSC-16 multi-cycle control unit and program counter.
// Sequences FETCH/DECODE/EXEC/MEM/WB around the register file's one-cycle read latency.
module risc16_control_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic [15:0] reg_out1,
   input  logic        alu_zero,
   output logic [15:0] pc,
   output logic [2:0]  rA,
   output logic [2:0]  rB,
   output logic [2:0]  rC,
   output logic        MUX_rf,
   output logic [1:0]  MUX_tgt,
   output logic        WE_rf,
   output logic [1:0]  alu_op,
   output logic        MUX_alu,
   output logic [15:0] imm,
   output logic        WE_dmem,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_ADDI = 3'b001,
      OP_NAND = 3'b010,
      OP_LUI  = 3'b011,
      OP_SW   = 3'b100,
      OP_LW   = 3'b101,
      OP_BEQ  = 3'b110,
      OP_JALR = 3'b111
   } opcode_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] tgt_q, tgt_d;

   opcode_t     op;
   logic        is_halt;
   logic        alu_active;
   logic [15:0] pc_inc;

   always_comb begin
      op = opcode_t'(ir_q[15:13]);
      case (op)
         OP_ADDI, OP_SW, OP_LW, OP_BEQ: imm = {{9{ir_q[6]}}, ir_q[6:0]};
         OP_LUI:                        imm = {ir_q[9:0], 6'b000000};
         default:                       imm = '0;
      endcase
      is_halt = (op == OP_JALR) && (ir_q[12:10] == 3'd0) && (ir_q[9:7] == 3'd0)
                && (ir_q[6:0] != 7'd0);
   end

   // Controls are gated by state so that reset (state=FETCH, IR=0) forces them all low at once.
   always_comb begin
      rA         = ir_q[12:10];
      rB         = ir_q[9:7];
      rC         = ir_q[2:0];
      pc         = pc_q;
      alu_active = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
      MUX_rf     = (alu_active || (state_q == S_DECODE)) && ((op == OP_SW) || (op == OP_BEQ));
      MUX_alu    = alu_active && ((op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_LUI));
      alu_op     = 2'b00;
      if (alu_active) begin
         case (op)
            OP_NAND: alu_op = 2'b01;
            OP_LUI:  alu_op = 2'b10;
            OP_BEQ:  alu_op = 2'b11;
            default: alu_op = 2'b00;
         endcase
      end
      MUX_tgt = 2'b00;
      if (state_q == S_WB) begin
         case (op)
            OP_LW:   MUX_tgt = 2'b00;
            OP_JALR: MUX_tgt = 2'b10;
            default: MUX_tgt = 2'b01;
         endcase
      end
      WE_rf   = (state_q == S_WB);
      WE_dmem = (state_q == S_MEM) && (op == OP_SW);
      halted  = (state_q == S_HALT);
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      tgt_d   = tgt_q;
      pc_inc  = pc_q + 16'd1;
      case (state_q)
         S_FETCH: begin
            ir_d    = instr;
            state_d = S_DECODE;
         end
         S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (op)
               OP_BEQ: begin
                  pc_d    = alu_zero ? (pc_inc + imm) : pc_inc;
                  state_d = S_FETCH;
               end
               OP_JALR: begin
                  tgt_d   = reg_out1;
                  state_d = S_WB;
               end
               OP_SW, OP_LW: state_d = S_MEM;
               default:      state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (op == OP_SW) begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            pc_d    = (op == OP_JALR) ? tgt_q : pc_inc;
            state_d = S_FETCH;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         tgt_q   <= tgt_d;
      end
   end

endmodule

// File: doc/risc16_control_unit.md
Name: risc16_control_unit

Overview:
- Multi-cycle control unit and program counter that sits directly upstream of register_file.
- Fetches a 16-bit RiSC-16 instruction and decodes it into rA/rB/rC, MUX_rf, MUX_tgt and WE_rf for the register file.
- Also drives ALU, immediate and data-memory controls.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB to match the register file's one-cycle registered read latency.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  16  instruction memory data at address pc; combinational, valid in FETCH.
- reg_out1  input  16  register_file read port 1 (rB value); JALR target.
- alu_zero  input  1  ALU equality flag (reg_out1 == reg_out2); used by BEQ.
- pc  output  16  current instruction address; instruction memory address and register_file pc input.
- rA, rB, rC  output  3 each  register fields of IR.
- MUX_rf  output  1  1 selects rA for read port 2 (SW, BEQ); else rC.
- MUX_tgt  output  2  00 mem, 01 alu, 10 pc+1.
- WE_rf  output  1  register write enable.
- alu_op  output  2  00 add, 01 nand, 10 pass imm, 11 compare.
- MUX_alu  output  1  1 selects imm as ALU operand B.
- imm  output  16  decoded immediate.
- WE_dmem  output  1  data memory write strobe.
- halted  output  1  high in HALT state.

Behaviour:
- Encoding: opcode = IR[15:13]; rA = IR[12:10]; rB = IR[9:7]; rC = IR[2:0].
- Opcodes: 000 ADD, 001 ADDI, 010 NAND, 011 LUI, 100 SW, 101 LW, 110 BEQ, 111 JALR.
- imm:
  - ADDI/SW/LW/BEQ: sign-extend IR[6:0].
  - LUI: {IR[9:0], 6'b0}.
  - Otherwise 0.
- HALT = JALR with rA=0, rB=0, IR[6:0] != 0.
- Registers: state, pc, IR, tgt (16-bit JALR/branch target). All are cleared asynchronously by rst: state=FETCH, pc=RESET_PC, IR=0, tgt=0.
- All control outputs are decoded combinationally from state and IR, so they fall to 0 immediately on rst. rA/rB/rC/imm follow IR=0. halted=0.
- States and actions:
  - FETCH: IR <= instr. Next state DECODE.
  - DECODE: rA/rB/rC/MUX_rf valid so register_file latches operands at this edge. Next state EXEC, or HALT if the HALT pattern is decoded.
  - EXEC: alu_op/MUX_alu valid; reg_out1/2 are valid this cycle.
    - BEQ: if alu_zero, pc <= pc+1+imm; else pc <= pc+1. Next state FETCH.
    - JALR: tgt <= reg_out1. Next state WB.
    - SW/LW: next state MEM.
    - Others: next state WB.
  - MEM:
    - SW: WE_dmem=1 for exactly this cycle; pc <= pc+1. Next state FETCH.
    - LW: next state WB.
  - WB: WE_rf=1 for exactly one cycle.
    - MUX_tgt: ADD/ADDI/NAND/LUI = 01; LW = 00; JALR = 10.
    - pc <= pc+1, or tgt for JALR. Next state FETCH.
    - register_file samples the old pc at the same edge, so the JALR link value = instruction address + 1.
  - HALT: all enables 0, halted=1, pc frozen. Exit only via rst.
- Per-instruction control settings:
  - MUX_rf = 1 for SW and BEQ, else 0.
  - MUX_alu = 1 for ADDI/LW/SW/LUI.
  - alu_op: 01 for NAND, 10 for LUI, 11 for BEQ, else 00.
- Cycle counts: ADD/ADDI/NAND/LUI/JALR = 4; LW = 5; SW = 4; BEQ = 3.
- Arithmetic: all pc arithmetic is 16-bit modulo; 16'hFFFF + 1 wraps to 0. BEQ offsets may be negative.
- Writes to rA=0 still assert WE_rf; register_file suppresses them.
- WE_rf and WE_dmem are never high simultaneously. Neither is ever high outside WB/MEM.
- Reset mid-instruction: the instruction is abandoned with no partial write. After rst deasserts, the first edge performs FETCH at RESET_PC.

Test Plan:
- Reset, then ADDI r1,r0,5 (16'h2405) at pc 0 → WB on the 4th edge: WE_rf=1, MUX_tgt=01, rA=1, imm=16'h0005, MUX_alu=1; pc becomes 1.
- LW r2,r1,-1 (16'hA8FF) → 5 cycles; imm=16'hFFFF; WB with MUX_tgt=00; WE_dmem never 1.
- SW r2,r1,3 (16'h8883) → MUX_rf=1 in DECODE; WE_dmem=1 in cycle 4 only; WE_rf stays 0.
- BEQ at pc 16'h0010 with imm=-3:
  - alu_zero=1 → pc=16'h000E after 3 cycles.
  - alu_zero=0 → pc=16'h0011.
- JALR r7,r3 at pc 16'h0020 with reg_out1=16'h0100 in EXEC → WB: MUX_tgt=10, rA=7, WE_rf=1, pc seen as 16'h0020; next pc = 16'h0100.
- Fetch 16'hE001 (HALT) → halted=1 after DECODE, pc frozen for 20 cycles. Assert rst during the WB of an ADD → WE_rf drops to 0 in the same cycle; pc returns to RESET_PC.
